// File: rtl/conv3x3_s2_sequencer.sv
// ---------------------------------------------------------------------------
// conv3x3_s2_sequencer
//   Controller for the layer0 conv datapath (mac_int8 -> bias add ->
//   leaky_relu -> requantize). Walks every output position (oh, ow) and
//   output channel ch of a 3x3 stride-2 convolution over a pre-padded INT8
//   map, issuing CIN*9 MACs per output, then bias add, leaky, requantize,
//   and one INT8 write to the output buffer.
//
// Ports
//   clk, rst_n             clock (rising edge), async active-low reset
//   start, scale_in        1-cycle start pulse, Q16 scale sampled on start
//   busy, done             pass in progress / 1-cycle end-of-pass pulse
//   act_*, wgt_*, bias_*   sync-read memory ports (data one cycle after addr)
//   mac_*                  mac_int8 issue / result
//   leaky_*                leaky_relu issue / result
//   req_*                  requantize issue / result
//   out_we/addr/data       output buffer write port
//
// Handshake: every *_valid and out_we is a single-cycle issue pulse raised
// only in its issue state; the matching *_done is looked at only in the
// state that waits for it, so early or stray done pulses are ignored.
// ---------------------------------------------------------------------------
module conv3x3_s2_sequencer #(
    parameter int CIN    = 3,
    parameter int H_PAD  = 9,
    parameter int W_PAD  = 9,
    parameter int H_OUT  = 4,
    parameter int W_OUT  = 4,
    parameter int NUM_CH = 32,
    parameter int STRIDE = 2,
    parameter int AW     = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [15:0]   scale_in,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] act_addr,
    input  logic [7:0]    act_rdata,
    output logic [AW-1:0] wgt_addr,
    input  logic [7:0]    wgt_rdata,
    output logic [AW-1:0] bias_addr,
    input  logic [31:0]   bias_rdata,
    output logic          mac_valid,
    output logic [7:0]    mac_weight,
    output logic [7:0]    mac_act,
    output logic [31:0]   mac_acc_in,
    input  logic [31:0]   mac_acc_out,
    input  logic          mac_done,
    output logic          leaky_valid,
    output logic [31:0]   leaky_x,
    input  logic [31:0]   leaky_y,
    input  logic          leaky_done,
    output logic          req_valid,
    output logic [31:0]   req_acc,
    output logic [15:0]   req_scale,
    input  logic [7:0]    req_out,
    input  logic          req_done,
    output logic          out_we,
    output logic [AW-1:0] out_addr,
    output logic [7:0]    out_data
);

    localparam logic [AW-1:0] LAST_TAP = AW'(CIN * 9 - 1);
    localparam logic [AW-1:0] LAST_OH  = AW'(H_OUT - 1);
    localparam logic [AW-1:0] LAST_OW  = AW'(W_OUT - 1);
    localparam logic [AW-1:0] LAST_CH  = AW'(NUM_CH - 1);
    localparam logic [AW-1:0] PLANE    = AW'(H_PAD * W_PAD);
    localparam logic [AW-1:0] WP       = AW'(W_PAD);
    localparam logic [AW-1:0] ST       = AW'(STRIDE);
    localparam logic [AW-1:0] WO       = AW'(W_OUT);
    localparam logic [AW-1:0] NC       = AW'(NUM_CH);
    localparam logic [AW-1:0] TAPS     = AW'(CIN * 9);
    localparam logic [AW-1:0] K_LAST   = AW'(2);

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_ISSUE, S_WAIT_MAC, S_BIAS_RD, S_LEAKY,
        S_WAIT_LEAKY, S_REQ, S_WAIT_REQ, S_WRITE, S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] oh_q, oh_d, ow_q, ow_d, ch_q, ch_d;
    // Tap index i plus its decoded form (c, ky, kx), stepped together so the
    // address path needs no divide by 9 / 3.
    logic [AW-1:0] i_q, i_d, c_q, c_d, ky_q, ky_d, kx_q, kx_d;
    logic [31:0]   acc_q, acc_d, leaky_q, leaky_d;
    logic [7:0]    res_q, res_d;
    logic [15:0]   scale_q, scale_d;

    logic [AW-1:0] act_calc, wgt_calc, out_calc;
    assign act_calc = c_q * PLANE + (oh_q * ST + ky_q) * WP + ow_q * ST + kx_q;
    assign wgt_calc = ch_q * TAPS + i_q;
    assign out_calc = (oh_q * WO + ow_q) * NC + ch_q;

    always_comb begin
        state_d = state_q;
        oh_d = oh_q;  ow_d = ow_q;  ch_d = ch_q;
        i_d = i_q;    c_d = c_q;    ky_d = ky_q;  kx_d = kx_q;
        acc_d = acc_q;  leaky_d = leaky_q;  res_d = res_q;  scale_d = scale_q;

        busy        = (state_q != S_IDLE) && (state_q != S_DONE);
        done        = 1'b0;
        act_addr    = '0;
        wgt_addr    = '0;
        bias_addr   = '0;
        mac_valid   = 1'b0;
        mac_weight  = '0;
        mac_act     = '0;
        mac_acc_in  = '0;
        leaky_valid = 1'b0;
        leaky_x     = '0;
        req_valid   = 1'b0;
        req_acc     = '0;
        req_scale   = scale_q;
        out_we      = 1'b0;
        out_addr    = '0;
        out_data    = '0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    scale_d = scale_in;
                    oh_d = '0;  ow_d = '0;  ch_d = '0;
                    i_d = '0;   c_d = '0;   ky_d = '0;  kx_d = '0;
                    acc_d = '0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                act_addr = act_calc;
                wgt_addr = wgt_calc;
                state_d  = S_ISSUE;
            end
            S_ISSUE: begin
                mac_valid  = 1'b1;
                mac_weight = wgt_rdata;
                mac_act    = act_rdata;
                mac_acc_in = acc_q;
                state_d    = S_WAIT_MAC;
            end
            S_WAIT_MAC: begin
                if (mac_done) begin
                    acc_d = mac_acc_out;
                    if (i_q == LAST_TAP) begin
                        state_d = S_BIAS_RD;
                    end else begin
                        i_d = i_q + 1'b1;
                        if (kx_q == K_LAST) begin
                            kx_d = '0;
                            if (ky_q == K_LAST) begin
                                ky_d = '0;
                                c_d  = c_q + 1'b1;
                            end else begin
                                ky_d = ky_q + 1'b1;
                            end
                        end else begin
                            kx_d = kx_q + 1'b1;
                        end
                        state_d = S_FETCH;
                    end
                end
            end
            S_BIAS_RD: begin
                bias_addr = ch_q;
                state_d   = S_LEAKY;
            end
            S_LEAKY: begin
                leaky_valid = 1'b1;
                leaky_x     = acc_q + bias_rdata;   // wraps, no saturation
                state_d     = S_WAIT_LEAKY;
            end
            S_WAIT_LEAKY: begin
                if (leaky_done) begin
                    leaky_d = leaky_y;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                req_valid = 1'b1;
                req_acc   = leaky_q;
                state_d   = S_WAIT_REQ;
            end
            S_WAIT_REQ: begin
                if (req_done) begin
                    res_d   = req_out;
                    acc_d   = '0;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                out_we   = 1'b1;
                out_addr = out_calc;
                out_data = res_q;
                i_d = '0;  c_d = '0;  ky_d = '0;  kx_d = '0;
                state_d = S_FETCH;
                if (ch_q != LAST_CH) begin
                    ch_d = ch_q + 1'b1;
                end else begin
                    ch_d = '0;
                    if (ow_q != LAST_OW) begin
                        ow_d = ow_q + 1'b1;
                    end else begin
                        ow_d = '0;
                        if (oh_q != LAST_OH) begin
                            oh_d = oh_q + 1'b1;
                        end else begin
                            oh_d    = '0;
                            state_d = S_DONE;
                        end
                    end
                end
            end
            S_DONE: begin
                done    = 1'b1;   // start seen here is deliberately dropped
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            oh_q <= '0;  ow_q <= '0;  ch_q <= '0;
            i_q <= '0;   c_q <= '0;   ky_q <= '0;  kx_q <= '0;
            acc_q <= '0;  leaky_q <= '0;  res_q <= '0;  scale_q <= '0;
        end else begin
            state_q <= state_d;
            oh_q <= oh_d;  ow_q <= ow_d;  ch_q <= ch_d;
            i_q <= i_d;    c_q <= c_d;    ky_q <= ky_d;  kx_q <= kx_d;
            acc_q <= acc_d;  leaky_q <= leaky_d;  res_q <= res_d;  scale_q <= scale_d;
        end
    end

endmodule

// File: tb/tb_conv3x3_s2_sequencer.sv
// ---------------------------------------------------------------------------
// tb_conv3x3_s2_sequencer
//   Directed bench: sync-read memory models, echo-style unit models with
//   programmable done latency, and a per-cycle monitor that checks fetch
//   addresses, bias-add results, scale, write order and pulse counts.
// ---------------------------------------------------------------------------
module tb_conv3x3_s2_sequencer;

    localparam int AW   = 16;
    localparam int TAPS = 27;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic          start;
    logic [15:0]   scale_in;
    logic          busy, done;
    logic [AW-1:0] act_addr, wgt_addr, bias_addr, out_addr;
    logic [7:0]    act_rdata, wgt_rdata;
    logic [31:0]   bias_rdata;
    logic          mac_valid, mac_done;
    logic [7:0]    mac_weight, mac_act;
    logic [31:0]   mac_acc_in, mac_acc_out;
    logic          leaky_valid, leaky_done;
    logic [31:0]   leaky_x, leaky_y;
    logic          req_valid, req_done;
    logic [31:0]   req_acc;
    logic [15:0]   req_scale;
    logic [7:0]    req_out;
    logic          out_we;
    logic [7:0]    out_data;

    conv3x3_s2_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .scale_in(scale_in),
        .busy(busy), .done(done),
        .act_addr(act_addr), .act_rdata(act_rdata),
        .wgt_addr(wgt_addr), .wgt_rdata(wgt_rdata),
        .bias_addr(bias_addr), .bias_rdata(bias_rdata),
        .mac_valid(mac_valid), .mac_weight(mac_weight), .mac_act(mac_act),
        .mac_acc_in(mac_acc_in), .mac_acc_out(mac_acc_out), .mac_done(mac_done),
        .leaky_valid(leaky_valid), .leaky_x(leaky_x), .leaky_y(leaky_y),
        .leaky_done(leaky_done),
        .req_valid(req_valid), .req_acc(req_acc), .req_scale(req_scale),
        .req_out(req_out), .req_done(req_done),
        .out_we(out_we), .out_addr(out_addr), .out_data(out_data)
    );

    // ---------------- memory + unit models ----------------
    logic [7:0]  act_val, wgt_val;
    logic [31:0] bias_val;
    logic        wrap_mode;      // act memory holds 1 only at address 0
    int          mac_delay, leaky_delay;

    always @(posedge clk) begin
        act_rdata  <= wrap_mode ? ((act_addr == '0) ? 8'd1 : 8'd0) : act_val;
        wgt_rdata  <= wgt_val;
        bias_rdata <= bias_val;
    end

    logic signed [15:0] mac_prod;
    assign mac_prod = $signed(mac_act) * $signed(mac_weight);

    int          mac_cnt, leaky_cnt, req_cnt;
    logic [31:0] mac_res, leaky_res;
    logic [7:0]  req_res;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mac_cnt <= 0;  leaky_cnt <= 0;  req_cnt <= 0;
            mac_res <= '0; leaky_res <= '0; req_res <= '0;
        end else begin
            if (mac_valid) begin
                mac_cnt <= mac_delay;
                mac_res <= mac_acc_in + {{16{mac_prod[15]}}, mac_prod};
            end else if (mac_cnt != 0) begin
                mac_cnt <= mac_cnt - 1;
            end
            if (leaky_valid) begin
                leaky_cnt <= leaky_delay;
                leaky_res <= leaky_x;
            end else if (leaky_cnt != 0) begin
                leaky_cnt <= leaky_cnt - 1;
            end
            if (req_valid) begin
                req_cnt <= 1;
                req_res <= req_acc[7:0];
            end else if (req_cnt != 0) begin
                req_cnt <= req_cnt - 1;
            end
        end
    end

    assign mac_done    = (mac_cnt == 1);
    assign mac_acc_out = mac_res;
    assign leaky_done  = (leaky_cnt == 1);
    assign leaky_y     = leaky_res;
    assign req_done    = (req_cnt == 1);
    assign req_out     = req_res;

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_errors = 0;
    int wr_n, tap_n, leaky_n, done_n;
    int taps_since, leaky_since, req_since;
    logic [31:0]   exp_leaky;
    logic [7:0]    exp_data;
    logic [15:0]   exp_scale;
    logic [AW-1:0] prev_act, prev_wgt;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    function automatic int exp_act(input int k, input int i);
        int oh, ow, c, ky, kx;
        oh = k / (4 * 32);
        ow = (k / 32) % 4;
        c  = i / 9;
        ky = (i % 9) / 3;
        kx = i % 3;
        return c * 81 + (oh * 2 + ky) * 9 + ow * 2 + kx;
    endfunction

    function automatic int exp_wgt(input int k, input int i);
        return (k % 32) * TAPS + i;
    endfunction

    task automatic new_pass();
        wr_n = 0; tap_n = 0; leaky_n = 0; done_n = 0;
        taps_since = 0; leaky_since = 0; req_since = 0;
    endtask

    // One cycle: wait for the falling edge, then check whatever the DUT shows.
    task automatic tick();
        @(negedge clk);
        if (mac_valid) begin
            check_val("fetch_act", 32'(prev_act), 32'(exp_act(wr_n, taps_since)));
            check_val("fetch_wgt", 32'(prev_wgt), 32'(exp_wgt(wr_n, taps_since)));
            if (wr_n == 197 && taps_since == 13) begin
                check_val("trace_act", 32'(prev_act), 32'd113);
                check_val("trace_wgt", 32'(prev_wgt), 32'd148);
            end
            tap_n++;
            taps_since++;
        end
        if (leaky_valid) begin
            check_val("leaky_x", leaky_x, exp_leaky);
            leaky_n++;
            leaky_since++;
        end
        if (req_valid) begin
            check_val("req_scale", 32'(req_scale), 32'(exp_scale));
            check_val("req_acc", req_acc, exp_leaky);
            req_since++;
        end
        if (out_we) begin
            check_val("out_addr", 32'(out_addr), 32'(wr_n));
            check_val("out_data", 32'(out_data), 32'(exp_data));
            check_val("mac_pulses", 32'(taps_since), 32'(TAPS));
            check_val("leaky_pulses", 32'(leaky_since), 32'd1);
            check_val("req_pulses", 32'(req_since), 32'd1);
            if (wr_n == 197) check_val("trace_out", 32'(out_addr), 32'd197);
            wr_n++;
            taps_since = 0; leaky_since = 0; req_since = 0;
        end
        if (done) begin
            done_n++;
            check_val("busy_at_done", 32'(busy), 32'd0);
        end
        prev_act = act_addr;
        prev_wgt = wgt_addr;
    endtask

    task automatic run_cycles(input int n);
        for (int c = 0; c < n; c++) tick();
    endtask

    task automatic pulse_start(input logic [15:0] s);
        start    = 1'b1;
        scale_in = s;
        tick();
        start    = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (done_n == 0 && n < budget) begin
            tick();
            n++;
        end
        check_val("done_seen", 32'(done_n), 32'd1);
    endtask

    task automatic run_until_writes(input int w, input int budget);
        int n = 0;
        while (wr_n < w && n < budget) begin
            tick();
            n++;
        end
        check_val("writes_reached", 32'(wr_n), 32'(w));
    endtask

    task automatic check_idle_outputs(input string p);
        check_val({p, "_busy"},  32'(busy), 0);
        check_val({p, "_done"},  32'(done), 0);
        check_val({p, "_addrs"}, 32'(act_addr | wgt_addr | bias_addr | out_addr), 0);
        check_val({p, "_strobes"}, 32'({mac_valid, leaky_valid, req_valid, out_we}), 0);
        check_val({p, "_mac_ops"}, 32'({mac_weight, mac_act}), 0);
        check_val({p, "_mac_acc"}, mac_acc_in, 0);
        check_val({p, "_leaky_x"}, leaky_x, 0);
        check_val({p, "_req_acc"}, req_acc, 0);
        check_val({p, "_req_scale"}, 32'(req_scale), 0);
        check_val({p, "_out_data"}, 32'(out_data), 0);
    endtask

    // Reset mid-pass: outputs clear at once and no write follows.
    task automatic abort_pass(input string p);
        int w;
        rst_n = 1'b0;
        tick();
        check_idle_outputs(p);
        tick();
        rst_n = 1'b1;
        w = wr_n;
        run_cycles(12);
        check_val({p, "_no_write"}, 32'(wr_n), 32'(w));
        check_val({p, "_idle_busy"}, 32'(busy), 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst_n = 1'b0; start = 1'b0; scale_in = '0;
        act_val = 8'd1; wgt_val = 8'd1; bias_val = '0; wrap_mode = 1'b0;
        mac_delay = 1; leaky_delay = 1;
        exp_leaky = 32'd27; exp_data = 8'd27; exp_scale = 16'h8000;
        prev_act = '0; prev_wgt = '0;
        new_pass();

        run_cycles(3);
        check_idle_outputs("reset");
        rst_n = 1'b1;
        run_cycles(2);

        // Start a pass, then abort it with reset after ~100 cycles.
        new_pass();
        pulse_start(16'h8000);
        run_cycles(100);
        abort_pass("midrst");

        // Full pass of ones from scratch; a second start mid-pass is ignored.
        new_pass();
        pulse_start(16'h8000);
        run_cycles(1000);
        pulse_start(16'h1111);
        wait_done(60000);
        check_val("total_writes", 32'(wr_n), 32'd512);
        check_val("total_macs", 32'(tap_n), 32'(512 * TAPS));
        check_val("total_leaky", 32'(leaky_n), 32'd512);
        run_cycles(5);
        check_val("done_once", 32'(done_n), 32'd1);
        check_val("idle_after_pass", 32'(busy), 0);

        // Extremes: -128 * 127 * 27 = -438912, low byte 0x80.
        act_val = 8'h80; wgt_val = 8'd127; bias_val = '0;
        exp_leaky = 32'hFFF9_4D80; exp_data = 8'h80; exp_scale = 16'h0042;
        new_pass();
        pulse_start(16'h0042);
        run_until_writes(8, 2000);
        abort_pass("neg_abort");

        // Slow units: results identical, still one pulse per issue.
        mac_delay = 5; leaky_delay = 3;
        new_pass();
        pulse_start(16'h0042);
        run_until_writes(4, 2000);
        abort_pass("slow_abort");
        mac_delay = 1; leaky_delay = 1;

        // Wrap: acc=1 from tap 0 only, bias max positive -> 0x80000000.
        wrap_mode = 1'b1; wgt_val = 8'd1; bias_val = 32'h7FFF_FFFF;
        exp_leaky = 32'h8000_0000; exp_data = 8'h00; exp_scale = 16'h0007;
        new_pass();
        pulse_start(16'h0007);
        run_until_writes(2, 500);
        abort_pass("wrap_abort");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
